// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state encoding and default width for serial_adder
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder used for the per-cycle add step
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one bit per cycle; SERIAL_ADDER_SUB_EN adds subtract mode
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;
  logic             accept, shift, last;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1, so cout ends up as NOT borrow
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign last = (cnt_q == CW'(WIDTH - 1));

  full_adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Sum bits enter at the MSB so the first (LSB) result bit lands at sum[0] after WIDTH shifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_load;
      carry_q <= c_load;
      cnt_q   <= '0;
    end else if (shift) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
      carry_q <= fa_carry;
      cnt_q   <= cnt_q + CW'(1);
      if (last) cout_q <= fa_carry;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits, legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; the single clock for all state.
REQ-003 Port: rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 Port: in_valid  input  1  operands a, b, cin presented.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  WIDTH  addend.
REQ-007 Port: b  input  WIDTH  addend (subtrahend in subtract mode).
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  sum and cout valid.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: sum  output  WIDTH  result.
REQ-012 Port: cout  output  1  carry-out of bit WIDTH-1.
REQ-013 Port: busy  output  1  high in RUN or DONE.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, RUN and DONE.
REQ-015 In IDLE: in_ready=1; when in_valid=1, latch a and b into shift registers, latch cin into the carry flop, clear the bit counter and go to RUN.
REQ-016 In RUN: each cycle, one full_adder SHALL combine the operand LSBs and the carry flop.
  - The full_adder sum bit SHALL shift into sum MSB-first, so that after WIDTH shifts bit 0 is at sum[0].
  - The operand registers SHALL shift right.
  - The carry flop SHALL capture the full_adder carry.
REQ-017 RUN SHALL last exactly WIDTH cycles; the counter SHALL be $clog2(WIDTH) bits wide, and the FSM SHALL go to DONE when the counter equals WIDTH-1.
REQ-018 In DONE: out_valid=1, sum and cout held stable; on out_ready=1, go to IDLE.
REQ-019 Latency: out_valid SHALL rise WIDTH+1 cycles after the accept edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-021 out_ready while not in DONE SHALL be ignored.
REQ-022 Result SHALL equal (a + b + cin) mod 2^WIDTH, with cout = bit WIDTH of the exact sum.
REQ-023 Throughput: one operation per WIDTH+2 cycles minimum; the DONE->IDLE handoff SHALL take one cycle, with no accept in DONE.

Reset
REQ-024 With rst_n=0 at a clk edge, the FSM SHALL go to IDLE, and the counter, operand registers, sum, cout and carry flop SHALL be 0.
REQ-025 After reset: in_ready=1, out_valid=0, busy=0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse.

Configuration
REQ-027 With macro SERIAL_ADDER_SUB_EN defined, a port sub (input, 1, subtract select) SHALL exist.
  - sub is latched at accept.
  - When sub=1: b is bitwise inverted at latch and the carry flop loads 1 (cin ignored), giving a - b with cout = NOT borrow.
REQ-028 Without SERIAL_ADDER_SUB_EN: no sub port and no inversion logic; add only.

Structure
REQ-029 A shared package serial_adder_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the WIDTH default constant.
REQ-030 The per-bit add SHALL instantiate the existing full_adder module (ports a, b, c, sum, carry) once; no other sub-modules.

Verification (WIDTH=8)
REQ-031 a=0x0F, b=0x01, cin=0 -> out_valid at accept+9, sum=0x10, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> sum and cout stable, in_ready=0; out_ready=1 -> IDLE the next cycle; in_valid pulses with other operands during RUN -> result unchanged.
REQ-034 rst_n=0 at the 4th RUN cycle -> next cycle IDLE, out_valid never asserted, sum=0; a new operation then completes correctly.
REQ-035 With SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
